stopwatch_bcd_core: RTL and testbench

Stopwatch timebase and BCD time register fed by the 1 kHz divided-clock square wave from the clock divider stage. It edge-detects that signal synchronously in the system clock domain; it never uses it as a clock. It counts 10 ms steps into a 4-digit BCD value SS.hh (00.00–99.99) under start/stop and clear control. Its output feeds the 7-segment display scanner downstream.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/bcd_digit_cnt.sv | 28 ++
 rtl/stopwatch_bcd_core.sv | 111 +++++++++++
 tb/tb_stopwatch_bcd_core.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core.
// State encoding and BCD limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_t;

  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [15:0] BCD_SAT = 16'h9999;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One decimal digit of the stopwatch.
// Carry is combinational so the chain ripples in one cycle.
module bcd_digit_cnt
  import stopwatch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  assign o_carry = i_inc & (o_digit == BCD_MAX);

  // Digit register; 9 and any illegal code roll to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_digit <= 4'd0;
    end else if (i_clr) begin
      o_digit <= 4'd0;
    end else if (i_inc) begin
      if (o_digit >= BCD_MAX) o_digit <= 4'd0;
      else                    o_digit <= o_digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_core.sv
// Stopwatch timebase: tick edge detect, prescaler,
// run/pause FSM and a saturating SS.hh BCD register.
module stopwatch_bcd_core
  import stopwatch_pkg::*;
#(
  parameter int MS_PER_COUNT = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick_clk,
  input  logic        i_start_stop,
  input  logic        i_clear,
  output logic [15:0] o_bcd,
  output logic        o_running,
  output logic        o_overflow
);

  localparam logic [3:0] PS_LAST = 4'(MS_PER_COUNT - 1);

  sw_state_t  state, state_nxt;
  logic [3:0] presc, presc_nxt;
  logic       tick_d;
  logic       ms_edge;
  logic       clr_all;
  logic       inc;
  logic [3:0] carry;

  assign ms_edge = i_tick_clk & ~tick_d;

  // Next state, prescaler and increment; clear beats start/stop beats count.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    clr_all   = 1'b0;
    inc       = 1'b0;
    if (i_clear) begin
      state_nxt = ST_IDLE;
      presc_nxt = 4'd0;
      clr_all   = 1'b1;
    end else if (i_start_stop) begin
      unique case (state)
        ST_IDLE:  state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_RUN;
        default:  state_nxt = state;
      endcase
    end else if (state == ST_RUN && ms_edge) begin
      if (presc == PS_LAST) begin
        presc_nxt = 4'd0;
        if (o_bcd == BCD_SAT) state_nxt = ST_DONE;
        else                  inc = 1'b1;
      end else begin
        presc_nxt = presc + 4'd1;
      end
    end
  end

  // State, prescaler, tick history and registered status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      presc      <= 4'd0;
      tick_d     <= 1'b0;
      o_running  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      tick_d     <= i_tick_clk;
      o_running  <= (state_nxt == ST_RUN);
      o_overflow <= (state_nxt == ST_DONE);
    end
  end

  bcd_digit_cnt u_d0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (clr_all),
    .i_inc   (inc),
    .o_digit (o_bcd[3:0]),
    .o_carry (carry[0])
  );

  bcd_digit_cnt u_d1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (clr_all),
    .i_inc   (carry[0]),
    .o_digit (o_bcd[7:4]),
    .o_carry (carry[1])
  );

  bcd_digit_cnt u_d2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (clr_all),
    .i_inc   (carry[1]),
    .o_digit (o_bcd[11:8]),
    .o_carry (carry[2])
  );

  bcd_digit_cnt u_d3 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (clr_all),
    .i_inc   (carry[2]),
    .o_digit (o_bcd[15:12]),
    .o_carry (carry[3])
  );

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core.
// Three instances (MS_PER_COUNT 1, 2, 10) share stimulus.
module tb_stopwatch_bcd_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        ss = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] bcd1, bcd2, bcd10;
  logic        run1, run2, run10;
  logic        ovf1, ovf2, ovf10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_core #(.MS_PER_COUNT(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick_clk(tick),
    .i_start_stop(ss), .i_clear(clr),
    .o_bcd(bcd1), .o_running(run1), .o_overflow(ovf1)
  );

  stopwatch_bcd_core #(.MS_PER_COUNT(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick_clk(tick),
    .i_start_stop(ss), .i_clear(clr),
    .o_bcd(bcd2), .o_running(run2), .o_overflow(ovf2)
  );

  stopwatch_bcd_core #(.MS_PER_COUNT(10)) u10 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick_clk(tick),
    .i_start_stop(ss), .i_clear(clr),
    .o_bcd(bcd10), .o_running(run10), .o_overflow(ovf10)
  );

  typedef struct {
    logic        ss;
    logic        clr;
    int          edges;
    logic [15:0] bcd;
    logic        run;
    logic        ovf;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic c);
    @(negedge clk);
    ss  = s;
    clr = c;
    @(negedge clk);
    ss  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick  = 1'b0;
    ss    = 1'b0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 0,    16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 100,  16'h0100, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 0,    16'h0100, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 7,    16'h0100, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1,    16'h0101, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 9,    16'h0110, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 0,    16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1000, 16'h1000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8999, 16'h9999, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1,    16'h9999, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 3,    16'h9999, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 0,    16'h0000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 5,    16'h0005, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 0,    16'h0005, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 2,    16'h0000, 1'b0, 1'b0};

    do_reset();
    chk("rst_bcd", bcd1, 16'h0000);
    chk("rst_run", {15'd0, run1}, 16'd0);
    chk("rst_ovf", {15'd0, ovf1}, 16'd0);

    // Main MS_PER_COUNT=1 sequence
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].ss || tbl[i].clr) pulse(tbl[i].ss, tbl[i].clr);
      edges(tbl[i].edges);
      chk($sformatf("v%0d_bcd", i), bcd1, tbl[i].bcd);
      chk($sformatf("v%0d_run", i), {15'd0, run1}, {15'd0, tbl[i].run});
      chk($sformatf("v%0d_ovf", i), {15'd0, ovf1}, {15'd0, tbl[i].ovf});
    end

    // MS_PER_COUNT=10: increments land on the 10th and 20th edge
    do_reset();
    pulse(1'b1, 1'b0);
    edges(9);
    chk("p10_e9", bcd10, 16'h0000);
    edges(1);
    chk("p10_e10", bcd10, 16'h0001);
    edges(15);
    chk("p10_e25", bcd10, 16'h0002);
    chk("p10_presc", {12'd0, u10.presc}, 16'd5);

    // MS_PER_COUNT=2: pause coinciding with terminal edge
    do_reset();
    pulse(1'b1, 1'b0);
    edges(1);
    chk("p2_pre", bcd2, 16'h0000);
    @(negedge clk);
    tick = 1'b1;
    ss   = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    ss   = 1'b0;
    chk("p2_pz_bcd", bcd2, 16'h0000);
    chk("p2_pz_run", {15'd0, run2}, 16'd0);
    edges(3);
    chk("p2_pz_hold", bcd2, 16'h0000);
    pulse(1'b1, 1'b0);
    edges(1);
    chk("p2_resume", bcd2, 16'h0001);
    chk("p2_run", {15'd0, run2}, 16'd1);

    // Async reset mid-RUN at 01.23
    do_reset();
    pulse(1'b1, 1'b0);
    edges(123);
    chk("ar_pre", bcd1, 16'h0123);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_bcd", bcd1, 16'h0000);
    chk("ar_run", {15'd0, run1}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edges(5);
    chk("ar_idle", bcd1, 16'h0000);
    chk("ar_idle_run", {15'd0, run1}, 16'd0);
    pulse(1'b1, 1'b0);
    edges(1);
    chk("ar_restart", bcd1, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
